mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of XFER cycles before a transfer is force-completed (legal range 2..255).
REQ-002 SHALL have port clk24, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports mN_valid, input, 1, master N (N=0,1) request valid.
REQ-005 SHALL have ports mN_addr, input, 32, master N byte address.
REQ-006 SHALL have ports mN_wdata, input, 32, master N write data.
REQ-007 SHALL have ports mN_wstrb, input, 4, master N byte write strobes (0 = read).
REQ-008 SHALL have ports mN_ready, output, 1, master N transfer-complete strobe.
REQ-009 SHALL have ports mN_rdata, output, 32, master N read data.
REQ-010 SHALL have ports s_valid/s_addr/s_wdata/s_wstrb, output, 1/32/32/4, shared slave request.
REQ-011 SHALL have ports s_ready/s_rdata, input, 1/32, shared slave completion and read data.
REQ-012 SHALL have port err_clr, input, 1, synchronous clear of timeout_err.
REQ-013 SHALL have port timeout_err, output, 1, sticky flag set on any forced completion.
REQ-014 SHALL have port owner, output, 1, index of the master granted in XFER (last grant otherwise).

Function
REQ-015 SHALL implement a two-state FSM: IDLE and XFER.
REQ-016 SHALL, in IDLE with any mN_valid=1, register a grant and enter XFER on the next edge; with no request, remain in IDLE.
REQ-017 SHALL grant the only requester when one mN_valid is high; when both are high, it SHALL grant the master not served by the most recent completed grant (round-robin).
REQ-018 SHALL drive s_valid=1 only in XFER, with s_addr/s_wdata/s_wstrb combinationally muxed from the owner; in IDLE s_valid=0 and s_wstrb=0.
REQ-019 SHALL, in XFER with s_ready=1, assert owner's mN_ready=1 and drive mN_rdata=s_rdata in the same cycle, then return to IDLE.
REQ-020 SHALL hold the non-owner's mN_ready=0 at all times; mN_rdata of the non-owner SHALL be 0.
REQ-021 SHALL give a minimum latency of one cycle from an IDLE request to s_valid, and an mN_ready no earlier than the first XFER cycle.
REQ-022 SHALL count XFER cycles in an 8-bit counter cleared on XFER entry; when the count reaches TIMEOUT-1 with s_ready=0, it SHALL assert owner mN_ready=1 with mN_rdata=0, set timeout_err, and return to IDLE.
REQ-023 SHALL, when s_ready=1 coincides with the timeout cycle, treat it as a normal completion (pass s_rdata; timeout_err unchanged).
REQ-024 SHALL, if the owner drops mN_valid in XFER before completion, return to IDLE on the next edge without asserting mN_ready or updating the round-robin pointer.
REQ-025 SHALL update the round-robin pointer only on normal or forced completion.
REQ-026 SHALL, when err_clr and a timeout occur in the same cycle, leave timeout_err set (set wins).
REQ-027 SHALL never issue back-to-back grants without at least one IDLE cycle between XFERs.

Reset
REQ-028 SHALL, on resetn=0, asynchronously force state IDLE, counter 0, timeout_err 0, owner 0, round-robin pointer "last served = 1" so master 0 wins the first contention.
REQ-029 SHALL, on reset during XFER, drop s_valid and all mN_ready within the reset assertion, with no completion reported.

Verification
REQ-030 SHALL pass: m0 read of 0x1000_0010, slave returns 0xDEADBEEF with s_ready one cycle after s_valid -> m0_ready pulses once, m0_rdata=0xDEADBEEF, m1_ready stays 0.
REQ-031 SHALL pass: m0 and m1 both request from reset -> m0 served first, then m1, then m0 again on the next contention.
REQ-032 SHALL pass: m1 write 0x2000_0000, wdata 0x000000A5, wstrb 0x1 -> s_addr/s_wdata/s_wstrb match exactly while s_valid=1.
REQ-033 SHALL pass: s_ready held 0, TIMEOUT=64 -> owner mN_ready rises in XFER cycle 64 with rdata 0; timeout_err=1 until err_clr pulse, then 0.
REQ-034 SHALL pass: resetn pulsed low mid-XFER -> s_valid=0 immediately, no mN_ready, next contention grants m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single shared memory slave.
// A grant is registered in IDLE and held for one XFER transaction. The transaction ends on one
// of three events: slave completion, forced completion after TIMEOUT cycles, or the owner
// withdrawing its request. The arbiter always passes through IDLE between two transactions.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk24,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  input  logic        err_clr,
  output logic        timeout_err,
  output logic        owner
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StXfer = 1'b1;

  // The counter starts at 0 on the first XFER cycle, so TIMEOUT-1 marks XFER cycle TIMEOUT.
  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;   // master served by the most recent completed grant
  logic       err_q, err_d;

  logic in_xfer;
  logic own_valid;
  logic done_ok;
  logic done_to;
  logic done;

  // Completion decode for the current owner
  always_comb begin
    in_xfer   = (state_q == StXfer);
    own_valid = owner_q ? m1_valid : m0_valid;
    // A withdrawn request takes priority: nothing is reported to a master that left.
    done_ok   = in_xfer && own_valid && s_ready;
    done_to   = in_xfer && own_valid && !s_ready && (cnt_q == CntLast);
    done      = done_ok || done_to;
  end

  // Next-state logic: grant selection, XFER cycle counting, round-robin and sticky error update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (m0_valid || m1_valid) begin
          state_d = StXfer;
          cnt_d   = 8'd0;
          // On contention the master that was not served last wins.
          owner_d = (m0_valid && m1_valid) ? ~last_q : m1_valid;
        end
      end
      StXfer: begin
        if (!own_valid || done) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (done) begin
          last_d = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
    // Setting on a forced completion wins over a simultaneous clear.
    if (done_to) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk24 or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Slave request mux and per-master completion outputs
  always_comb begin
    s_valid     = in_xfer;
    s_addr      = owner_q ? m1_addr  : m0_addr;
    s_wdata     = owner_q ? m1_wdata : m0_wdata;
    s_wstrb     = in_xfer ? (owner_q ? m1_wstrb : m0_wstrb) : 4'h0;
    m0_ready    = done && !owner_q;
    m1_ready    = done && owner_q;
    m0_rdata    = (done_ok && !owner_q) ? s_rdata : 32'h0;
    m1_rdata    = (done_ok && owner_q) ? s_rdata : 32'h0;
    timeout_err = err_q;
    owner       = owner_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal expectations, followed by
// randomized master/slave traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int unsigned TO = 64;

  logic        clk24 = 1'b0;
  logic        resetn = 1'b0;
  logic        mv [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        err_clr;

  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        timeout_err;
  logic        owner;

  always #5 clk24 = ~clk24;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk24       (clk24),
    .resetn      (resetn),
    .m0_valid    (mv[0]),
    .m0_addr     (ma[0]),
    .m0_wdata    (mw[0]),
    .m0_wstrb    (ms[0]),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m1_valid    (mv[1]),
    .m1_addr     (ma[1]),
    .m1_wdata    (mw[1]),
    .m1_wstrb    (ms[1]),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .err_clr     (err_clr),
    .timeout_err (timeout_err),
    .owner       (owner)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------------
  // Transaction-level model: busy flag, current owner, XFER cycle number (1-based), last served.
  // ---------------------------------------------------------------------------------------------
  bit md_busy, md_own, md_last, md_err;
  int md_cyc;
  bit nx_busy, nx_own, nx_last, nx_err;
  int nx_cyc;
  int n_ok = 0, n_to = 0, n_ab = 0;

  bit          ov, ok, to;
  logic        e_r0, e_r1;
  logic [31:0] e_d0, e_d1;
  logic [3:0]  e_strb;

  // Compare process: outputs are combinational on registered state and inputs; check mid-cycle.
  always @(negedge clk24) begin
    if (!resetn) begin
      chk("rst s_valid", {31'd0, s_valid}, 32'd0);
      chk("rst m0_ready", {31'd0, m0_ready}, 32'd0);
      chk("rst m1_ready", {31'd0, m1_ready}, 32'd0);
      chk("rst timeout_err", {31'd0, timeout_err}, 32'd0);
      chk("rst owner", {31'd0, owner}, 32'd0);
      chk("rst s_wstrb", {28'd0, s_wstrb}, 32'd0);
      nx_busy = 1'b0; nx_own = 1'b0; nx_last = 1'b1; nx_err = 1'b0; nx_cyc = 0;
    end else begin
      ok = 1'b0; to = 1'b0;
      e_r0 = 1'b0; e_r1 = 1'b0; e_d0 = 32'h0; e_d1 = 32'h0; e_strb = 4'h0;
      nx_busy = md_busy; nx_own = md_own; nx_last = md_last; nx_cyc = md_cyc;
      if (md_busy) begin
        ov = mv[md_own];
        ok = ov && s_ready;
        to = ov && !s_ready && (md_cyc == TO);
        e_strb = ms[md_own];
        chk("s_addr", s_addr, ma[md_own]);
        chk("s_wdata", s_wdata, mw[md_own]);
        if (ok || to) begin
          if (md_own) e_r1 = 1'b1; else e_r0 = 1'b1;
          if (ok) begin
            if (md_own) e_d1 = s_rdata; else e_d0 = s_rdata;
            n_ok++;
          end else begin
            n_to++;
          end
          nx_busy = 1'b0;
          nx_last = md_own;
        end else if (!ov) begin
          nx_busy = 1'b0;
          n_ab++;
        end else begin
          nx_cyc = md_cyc + 1;
        end
      end else if (mv[0] || mv[1]) begin
        nx_busy = 1'b1;
        nx_cyc  = 1;
        nx_own  = (mv[0] && mv[1]) ? !md_last : mv[1];
      end
      nx_err = to ? 1'b1 : (err_clr ? 1'b0 : md_err);
      chk("s_valid", {31'd0, s_valid}, {31'd0, md_busy});
      chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, e_strb});
      chk("m0_ready", {31'd0, m0_ready}, {31'd0, e_r0});
      chk("m1_ready", {31'd0, m1_ready}, {31'd0, e_r1});
      chk("m0_rdata", m0_rdata, e_d0);
      chk("m1_rdata", m1_rdata, e_d1);
      chk("timeout_err", {31'd0, timeout_err}, {31'd0, md_err});
      chk("owner", {31'd0, owner}, {31'd0, md_own});
    end
  end

  // Model state advance, reset asynchronously like the design
  always @(posedge clk24 or negedge resetn) begin
    if (!resetn) begin
      md_busy <= 1'b0; md_own <= 1'b0; md_last <= 1'b1; md_err <= 1'b0; md_cyc <= 0;
    end else begin
      md_busy <= nx_busy; md_own <= nx_own; md_last <= nx_last; md_err <= nx_err;
      md_cyc <= nx_cyc;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk24);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; ma[i] = 32'h0; mw[i] = 32'h0; ms[i] = 4'h0;
    end
    s_ready = 1'b0; s_rdata = 32'h0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  int   got [$];
  int   hit;
  logic [31:0] rd;
  logic r0, r1, rdy;

  initial begin
    idle_inputs();
    do_reset();

    // Single m0 read, slave answers on the second XFER cycle.
    mv[0] = 1'b1; ma[0] = 32'h1000_0010;
    tick();
    #1 chk("030 s_valid", {31'd0, s_valid}, 32'd1);
    chk("030 m0_ready early", {31'd0, m0_ready}, 32'd0);
    tick();
    s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
    #1 chk("030 m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("030 m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("030 m1_ready", {31'd0, m1_ready}, 32'd0);
    tick();
    mv[0] = 1'b0; s_ready = 1'b0;
    #1 chk("030 m0_ready after", {31'd0, m0_ready}, 32'd0);
    chk("030 s_valid idle", {31'd0, s_valid}, 32'd0);

    // Contention from reset: m0, m1, m0.
    do_reset();
    mv[0] = 1'b1; mv[1] = 1'b1; s_ready = 1'b1; s_rdata = 32'h1234_5678;
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      tick();
      #1;
      if (m0_ready) got.push_back(0);
      if (m1_ready) got.push_back(1);
    end
    chk("031 grant count", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("031 first", got[0], 32'd0);
      chk("031 second", got[1], 32'd1);
      chk("031 third", got[2], 32'd0);
    end
    tick();
    mv[0] = 1'b0; mv[1] = 1'b0; s_ready = 1'b0;

    // m1 write passthrough.
    do_reset();
    mv[1] = 1'b1; ma[1] = 32'h2000_0000; mw[1] = 32'h0000_00A5; ms[1] = 4'h1;
    tick();
    #1 chk("032 s_valid", {31'd0, s_valid}, 32'd1);
    chk("032 s_addr", s_addr, 32'h2000_0000);
    chk("032 s_wdata", s_wdata, 32'h0000_00A5);
    chk("032 s_wstrb", {28'd0, s_wstrb}, 32'h1);
    chk("032 owner", {31'd0, owner}, 32'd1);
    s_ready = 1'b1;
    #1 chk("032 m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("032 m0_ready", {31'd0, m0_ready}, 32'd0);
    tick();
    mv[1] = 1'b0; s_ready = 1'b0;

    // Timeout with the slave silent; forced completion on XFER cycle TO.
    do_reset();
    mv[0] = 1'b1;
    tick();
    hit = 0; rd = 32'hFFFF_FFFF;
    for (int k = 1; k <= 80; k++) begin
      #1;
      if (m0_ready) begin
        hit = k; rd = m0_rdata;
        break;
      end
      tick();
    end
    chk("033 timeout cycle", hit, TO);
    chk("033 timeout rdata", rd, 32'h0);
    tick();
    mv[0] = 1'b0;
    #1 chk("033 err set", {31'd0, timeout_err}, 32'd1);
    tick();
    #1 chk("033 err sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1 chk("033 err cleared", {31'd0, timeout_err}, 32'd0);

    // Timeout while err_clr is held: the set must win on the timeout edge.
    mv[0] = 1'b1; err_clr = 1'b1;
    tick();
    repeat (TO - 1) tick();
    #1 chk("026 forced ready", {31'd0, m0_ready}, 32'd1);
    tick();
    #1 chk("026 set wins", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b0; mv[0] = 1'b0;
    tick();

    // Reset in the middle of an m1 transfer.
    do_reset();
    mv[0] = 1'b1; s_ready = 1'b1;
    tick();
    tick();
    mv[1] = 1'b1; s_ready = 1'b0;
    tick();
    #1 chk("034 owner m1", {31'd0, owner}, 32'd1);
    chk("034 s_valid", {31'd0, s_valid}, 32'd1);
    tick();
    resetn = 1'b0; s_ready = 1'b1;
    #1 chk("034 s_valid in reset", {31'd0, s_valid}, 32'd0);
    chk("034 m0_ready in reset", {31'd0, m0_ready}, 32'd0);
    chk("034 m1_ready in reset", {31'd0, m1_ready}, 32'd0);
    chk("034 owner in reset", {31'd0, owner}, 32'd0);
    tick();
    resetn = 1'b1; s_ready = 1'b0;
    tick();
    #1 chk("034 regrant owner", {31'd0, owner}, 32'd0);
    chk("034 regrant s_valid", {31'd0, s_valid}, 32'd1);
    mv[0] = 1'b0; mv[1] = 1'b0;

    // Randomized traffic: fast slave first, then a slow one that triggers timeouts.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk24);
      r0 = m0_ready; r1 = m1_ready;
      @(posedge clk24);
      #1;
      for (int i = 0; i < 2; i++) begin
        rdy = (i == 1) ? r1 : r0;
        if (mv[i] && !rdy) begin
          if ($urandom_range(0, 49) == 0) mv[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
          mv[i] = 1'b1;
          ma[i] = $urandom;
          mw[i] = $urandom;
          ms[i] = 4'($urandom_range(0, 15));
        end else begin
          mv[i] = 1'b0;
        end
      end
      s_ready = (c < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
      s_rdata = $urandom;
      err_clr = ($urandom_range(0, 15) == 0);
    end
    idle_inputs();
    tick();
    tick();
    chk("random normal completions seen", {31'd0, n_ok > 0}, 32'd1);
    chk("random timeouts seen", {31'd0, n_to > 0}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
